regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
// - Parametrised integer register file for the pipelined core: NRD combinational read ports,
//   one writeback port, plus a per-register scoreboard (busy bits) for RAW hazard detection.
// - Decode issues destination reg (sets busy); WB writes data (clears busy); flush clears all.
// - Sits between ID (reads, issue) and WB (write); hazard unit consumes rd_busy / busy_cnt.
// PARAMETERS
// - XLEN    32  data width in bits
// - NREGS   32  register count (power of 2, >=2); AW = $clog2(NREGS)
// - NRD     2   number of read ports (1..4)
// PORTS
// - clk        in   1         clock, all state updates on rising edge
// - rst_n      in   1         synchronous active-low reset
// - rd_addr    in   NRD*AW    read addresses, port i at [i*AW +: AW]
// - rd_data    out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
// - rd_busy    out  NRD       port i source has a pending (issued, not written back) producer
// - iss_valid  in   1         decode issues an instruction with a destination register
// - iss_rd     in   AW        destination register of issued instruction
// - wb_en      in   1         writeback enable
// - wb_rd      in   AW        writeback register address
// - wb_data    in   XLEN      writeback data
// - flush      in   1         clear all busy bits (mispredict/trap); data untouched
// - busy_cnt   out  AW+1      number of registers currently busy (registered)
// BEHAVIOUR
// - Reset (rst_n==0 at posedge): all regs <= 0, all busy <= 0, busy_cnt <= 0.
//   While rst_n==0, rd_data = 0 and rd_busy = 0 combinationally on every port.
// - Register 0 hardwired: reads return 0, rd_busy=0; writes to 0 dropped; issue to 0 sets nothing.
// - Write: wb_en && wb_rd!=0 -> regs[wb_rd] <= wb_data at posedge (1-cycle write latency).
// - Read: combinational, zero latency; all NRD ports independent, same address allowed.
// - Busy update per reg r, priority order at each posedge:
//   1. flush=1 -> busy[r] <= 0 for all r (overrides issue and WB clear in same cycle).
//   2. iss_valid && iss_rd==r -> busy[r] <= 1 (issue wins over same-cycle WB to r: new producer).
//   3. wb_en && wb_rd==r -> busy[r] <= 0.
//   WB to a non-busy reg still writes data; busy stays 0. Re-issue to busy reg keeps it 1.
// - rd_busy[i] = busy[rd_addr[i]] from registered state; in bypass mode it is also forced 0
//   when wb_en && wb_rd==rd_addr[i] && !(the reg was re-issued this cycle is irrelevant: state only).
// - busy_cnt tracks popcount(busy) exactly: next = popcount(next busy vector); flush -> 0;
//   saturation impossible (max NREGS-1, fits AW+1 bits).
// - No handshake backpressure: block always accepts issue/WB; hazard unit must stall decode.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined: write-through forwarding. If wb_en && wb_rd==rd_addr[i] && wb_rd!=0,
//   rd_data[i] = wb_data and rd_busy[i] = 0 in the same cycle.
// - REGFILE_BYPASS_EN undefined: rd_data[i] = stored value; new data visible the cycle after WB;
//   rd_busy[i] reflects stored busy bit only (stays 1 during the WB cycle).
// - Reset-held (rst_n==0) zero outputs take priority over bypass in both builds.
// TESTING
// - Reset: hold rst_n=0 2 cycles with wb_en=1 wb_rd=5 -> regs all 0, busy_cnt=0, rd_data=0.
// - Write/read: wb x3<=32'hDEADBEEF; next cycle rd_addr0=3,rd_addr1=3 -> both 32'hDEADBEEF.
// - Zero reg: wb x0<=32'h1234, iss_rd=0 -> reads of x0 return 0, rd_busy=0, busy_cnt=0.
// - Scoreboard: issue x7 -> rd_busy=1, busy_cnt=1; same cycle issue x7 + wb x7 -> busy stays 1;
//   later wb x7 alone -> busy 0, busy_cnt 0.
// - Flush: issue x1,x2,x3 on 3 cycles (busy_cnt=3); flush with iss_rd=4 -> busy_cnt=0, x4 not busy.
// - Bypass: wb x9<=32'hA5A5A5A5 with rd_addr0=9 same cycle -> 32'hA5A5A5A5, rd_busy0=0 with
//   REGFILE_BYPASS_EN; old value and rd_busy0=1 (if issued) without it.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard and busy count.
// Define REGFILE_BYPASS_EN for write-through forwarding from the WB port.
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nx;
  logic [AW:0]      cnt_nx;

  // Issue is applied after WB clear so a new producer wins.
  always_comb begin
    busy_nx = busy;
    if (flush) begin
      busy_nx = '0;
    end else begin
      if (wb_en) busy_nx[wb_rd] = 1'b0;
      if (iss_valid && iss_rd != '0)
        busy_nx[iss_rd] = 1'b1;
    end
    cnt_nx = '0;
    for (int r = 0; r < NREGS; r++)
      cnt_nx = cnt_nx + {{AW{1'b0}}, busy_nx[r]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wb_en && wb_rd != '0)
        regs[wb_rd] <= wb_data;
      busy     <= busy_nx;
      busy_cnt <= cnt_nx;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign hit = wb_en && (wb_rd == a)
                 && (a != '0);
`else
    assign hit = 1'b0;
`endif
    assign rd_data[i*XLEN +: XLEN] =
      (!rst_n || a == '0) ? '0 :
      hit ? wb_data : regs[a];
    assign rd_busy[i] = rst_n && !hit
                        && busy[a];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard against a
// behavioural array model of registers and busy flags.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic [5:0]  busy_cnt;

  int n_chk;
  int n_pass;

  logic [31:0] mregs [32];
  bit          mbusy [32];

  regfile_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flush     (flush),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic drv(input bit rs,
                     input bit iv, input int ird,
                     input bit we, input int wrd,
                     input logic [31:0] wd,
                     input bit fl,
                     input int a0, input int a1);
    @(negedge clk);
    rst_n     = rs;
    iss_valid = iv;
    iss_rd    = 5'(ird);
    wb_en     = we;
    wb_rd     = 5'(wrd);
    wb_data   = wd;
    flush     = fl;
    rd_addr   = {5'(a1), 5'(a0)};
    #1;
  endtask

  function automatic int mcount();
    int c = 0;
    for (int r = 0; r < 32; r++)
      if (mbusy[r]) c++;
    return c;
  endfunction

  // Expected read view: stored state, optional forward.
  task automatic mchk();
    for (int p = 0; p < 2; p++) begin
      int a;
      logic [31:0] ed;
      bit eb;
      a  = int'(rd_addr[p*5 +: 5]);
      ed = 32'h0;
      eb = 1'b0;
      if (rst_n && a != 0) begin
        ed = mregs[a];
        eb = mbusy[a];
`ifdef REGFILE_BYPASS_EN
        if (wb_en && int'(wb_rd) == a) begin
          ed = wb_data;
          eb = 1'b0;
        end
`endif
      end
      chk($sformatf("rd_data%0d", p),
          64'(rd_data[p*32 +: 32]), 64'(ed));
      chk($sformatf("rd_busy%0d", p),
          64'(rd_busy[p]), 64'(eb));
    end
    chk("busy_cnt", 64'(busy_cnt), 64'(mcount()));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        mregs[r] = 32'h0;
        mbusy[r] = 1'b0;
      end
    end else begin
      if (wb_en && wb_rd != 0)
        mregs[wb_rd] = wb_data;
      if (flush) begin
        for (int r = 0; r < 32; r++)
          mbusy[r] = 1'b0;
      end else begin
        if (wb_en) mbusy[wb_rd] = 1'b0;
        if (iss_valid && iss_rd != 0)
          mbusy[iss_rd] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int a0, input int a1);
    drv(1, 0, 0, 0, 0, 32'h0, 0, a0, a1);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int r = 0; r < 32; r++) begin
      mregs[r] = 32'h0;
      mbusy[r] = 1'b0;
    end

    // reset held two cycles with a WB attempt
    drv(0, 1, 6, 1, 5, 32'hFFFF_0000, 0, 5, 6);
    chk("rst_rd0", 64'(rd_data[31:0]), 64'h0);
    chk("rst_busy", 64'(rd_busy), 64'h0);
    tick();
    drv(0, 1, 6, 1, 5, 32'hFFFF_0000, 0, 5, 6);
    mchk();
    tick();
    idle(5, 6);
    mchk();
    chk("rst_x5", 64'(rd_data[31:0]), 64'h0);
    chk("rst_cnt", 64'(busy_cnt), 64'h0);
    tick();

    // write then read on both ports
    drv(1, 0, 0, 1, 3, 32'hDEADBEEF, 0, 1, 2);
    mchk();
    tick();
    idle(3, 3);
    mchk();
    chk("x3_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("x3_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
    tick();

    // register zero
    drv(1, 1, 0, 1, 0, 32'h1234, 0, 0, 0);
    mchk();
    tick();
    idle(0, 0);
    mchk();
    chk("x0_rd", 64'(rd_data[31:0]), 64'h0);
    chk("x0_busy", 64'(rd_busy[0]), 64'h0);
    chk("x0_cnt", 64'(busy_cnt), 64'h0);
    tick();

    // scoreboard issue / same-cycle issue+WB
    drv(1, 1, 7, 0, 0, 32'h0, 0, 7, 0);
    mchk();
    tick();
    drv(1, 1, 7, 1, 7, 32'h5555_0007, 0, 7, 0);
    mchk();
    chk("x7_cnt1", 64'(busy_cnt), 64'h1);
    tick();
    idle(7, 7);
    mchk();
    chk("x7_still", 64'(rd_busy[0]), 64'h1);
    tick();
    drv(1, 0, 0, 1, 7, 32'h7777_0007, 0, 7, 0);
    mchk();
    tick();
    idle(7, 0);
    mchk();
    chk("x7_clr", 64'(rd_busy[0]), 64'h0);
    chk("x7_cnt0", 64'(busy_cnt), 64'h0);
    tick();

    // flush overrides issue
    for (int r = 1; r <= 3; r++) begin
      drv(1, 1, r, 0, 0, 32'h0, 0, r, 4);
      mchk();
      tick();
    end
    idle(1, 4);
    chk("fl_cnt3", 64'(busy_cnt), 64'h3);
    tick();
    drv(1, 1, 4, 0, 0, 32'h0, 1, 2, 4);
    mchk();
    tick();
    idle(4, 1);
    mchk();
    chk("fl_cnt0", 64'(busy_cnt), 64'h0);
    chk("fl_x4", 64'(rd_busy[0]), 64'h0);
    tick();

    // bypass window
    drv(1, 1, 9, 0, 0, 32'h0, 0, 9, 9);
    mchk();
    tick();
    drv(1, 0, 0, 1, 9, 32'hA5A5A5A5, 0, 9, 0);
    mchk();
`ifdef REGFILE_BYPASS_EN
    chk("byp_d", 64'(rd_data[31:0]), 64'hA5A5A5A5);
    chk("byp_b", 64'(rd_busy[0]), 64'h0);
`else
    chk("byp_d", 64'(rd_data[31:0]), 64'h0);
    chk("byp_b", 64'(rd_busy[0]), 64'h1);
`endif
    tick();
    idle(9, 0);
    chk("byp_nx", 64'(rd_data[31:0]), 64'hA5A5A5A5);
    tick();

    // random traffic, biased to a few regs
    for (int n = 0; n < 600; n++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
      drv(($urandom_range(0, 63) != 0),
          $urandom_range(0, 1),
          $urandom_range(0, lim),
          $urandom_range(0, 1),
          $urandom_range(0, lim),
          $urandom,
          ($urandom_range(0, 19) == 0),
          $urandom_range(0, lim),
          $urandom_range(0, lim));
      mchk();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
